// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register file write port: picks one writeback per cycle
// and registers it onto write_en / wr_reg_num / write_data.
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] wr_reg_num,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  grant_id
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic                  last_grant_q;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  gnt0, gnt1, xfer;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  write_en_q, grant_id_q;
  logic [REG_ADDR_W-1:0] wr_reg_num_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid;
    if (req0_valid && req1_valid) begin
      if (PRIORITY_MODE == 0) begin
        gnt1 = (last_grant_q == 1'b0);
      end else begin
        gnt1 = (starve_cnt_q == StarveMax);
      end
      gnt0 = !gnt1;
    end
  end

  assign xfer     = gnt0 || gnt1;
  assign sel_rd   = gnt1 ? req1_rd : req0_rd;
  assign sel_data = gnt1 ? req1_data : req0_data;

  // Counts only stalled cycles of a waiting requester 1; any gap or grant restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1_valid || gnt1) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      starve_cnt_q <= 4'd0;
      write_en_q   <= 1'b0;
      wr_reg_num_q <= '0;
      write_data_q <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      // x0 writes are still accepted and arbitrated, just never committed.
      write_en_q   <= xfer && (sel_rd != '0);
      if (xfer) begin
        last_grant_q <= gnt1;
        wr_reg_num_q <= sel_rd;
        write_data_q <= sel_data;
        grant_id_q   <= gnt1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign write_en   = write_en_q;
  assign wr_reg_num = wr_reg_num_q;
  assign write_data = write_data_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  rd0 = '0, rd1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic        rr_rdy0, rr_rdy1, rr_we, rr_gid;
  logic [4:0]  rr_wr;
  logic [31:0] rr_wd;
  logic        fp_rdy0, fp_rdy1, fp_we, fp_gid;
  logic [4:0]  fp_wr;
  logic [31:0] fp_wd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_WIDTH(32), .REG_ADDR_W(5), .PRIORITY_MODE(0), .STARVE_LIMIT(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_rd(rd0), .req0_data(d0), .req0_ready(rr_rdy0),
    .req1_valid(v1), .req1_rd(rd1), .req1_data(d1), .req1_ready(rr_rdy1),
    .write_en(rr_we), .wr_reg_num(rr_wr), .write_data(rr_wd), .grant_id(rr_gid)
  );

  rf_write_arbiter #(.DATA_WIDTH(32), .REG_ADDR_W(5), .PRIORITY_MODE(1), .STARVE_LIMIT(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_rd(rd0), .req0_data(d0), .req0_ready(fp_rdy0),
    .req1_valid(v1), .req1_rd(rd1), .req1_data(d1), .req1_ready(fp_rdy1),
    .write_en(fp_we), .wr_reg_num(fp_wr), .write_data(fp_wd), .grant_id(fp_gid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v0 = 1'b0;
    v1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_we_rr", rr_we, 1'b0);
    check("rst_wr_rr", rr_wr, 5'd0);
    check("rst_wd_rr", rr_wd, 32'd0);
    check("rst_gid_rr", rr_gid, 1'b0);
    check("rst_rdy_rr", {rr_rdy0, rr_rdy1}, 2'b00);
    check("rst_we_fp", fp_we, 1'b0);
    do_reset();

    // req0 alone
    v0 = 1'b1; rd0 = 5'd5; d0 = 32'hDEADBEEF;
    #1;
    check("t1_rdy_rr", {rr_rdy0, rr_rdy1}, 2'b10);
    check("t1_rdy_fp", {fp_rdy0, fp_rdy1}, 2'b10);
    tick();
    v0 = 1'b0;
    check("t1_we", rr_we, 1'b1);
    check("t1_wr", rr_wr, 5'd5);
    check("t1_wd", rr_wd, 32'hDEADBEEF);
    check("t1_gid", rr_gid, 1'b0);
    check("t1_fp", {fp_we, fp_wr, fp_wd, fp_gid}, {1'b1, 5'd5, 32'hDEADBEEF, 1'b0});
    tick();
    check("t1_idle_we", rr_we, 1'b0);
    check("t1_hold_wr", rr_wr, 5'd5);
    check("t1_hold_wd", rr_wd, 32'hDEADBEEF);

    // Continuous tie: RR alternates 0,1,...; FP grants req1 every 5th cycle
    do_reset();
    v0 = 1'b1; rd0 = 5'd1; d0 = 32'h100;
    v1 = 1'b1; rd1 = 5'd2; d1 = 32'h200;
    for (int i = 0; i < 10; i++) begin
      logic rr_g, fp_g;
      rr_g = (i % 2) == 1;
      fp_g = (i % 5) == 4;
      #1;
      check($sformatf("tie_rdy_rr%0d", i), {rr_rdy0, rr_rdy1}, {!rr_g, rr_g});
      check($sformatf("tie_rdy_fp%0d", i), {fp_rdy0, fp_rdy1}, {!fp_g, fp_g});
      tick();
      check($sformatf("tie_out_rr%0d", i), {rr_we, rr_gid, rr_wr, rr_wd},
            {1'b1, rr_g, rr_g ? 5'd2 : 5'd1, rr_g ? 32'h200 : 32'h100});
      check($sformatf("tie_out_fp%0d", i), {fp_we, fp_gid, fp_wr, fp_wd},
            {1'b1, fp_g, fp_g ? 5'd2 : 5'd1, fp_g ? 32'h200 : 32'h100});
    end
    v0 = 1'b0; v1 = 1'b0;

    // x0 write by req1 after a req0 grant: accepted, not committed, last_grant moves to 1
    do_reset();
    v0 = 1'b1; rd0 = 5'd3; d0 = 32'h33;
    tick();
    v0 = 1'b0;
    v1 = 1'b1; rd1 = 5'd0; d1 = 32'h1234;
    #1;
    check("x0_rdy", {rr_rdy0, rr_rdy1}, 2'b01);
    tick();
    check("x0_we_rr", rr_we, 1'b0);
    check("x0_we_fp", fp_we, 1'b0);
    v0 = 1'b1; rd0 = 5'd4; d0 = 32'h44;
    rd1 = 5'd6; d1 = 32'h66;
    #1;
    check("x0_tie_rr", {rr_rdy0, rr_rdy1}, 2'b10);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    check("x0_tie_out", {rr_we, rr_wr, rr_wd, rr_gid}, {1'b1, 5'd4, 32'h44, 1'b0});

    // Same rd from both requesters, RR from reset
    do_reset();
    v0 = 1'b1; rd0 = 5'd7; d0 = 32'hAAAA;
    v1 = 1'b1; rd1 = 5'd7; d1 = 32'h5555;
    tick();
    v0 = 1'b0;
    check("rd7_first", {rr_we, rr_wr, rr_wd, rr_gid}, {1'b1, 5'd7, 32'hAAAA, 1'b0});
    #1;
    check("rd7_rdy1", {rr_rdy0, rr_rdy1}, 2'b01);
    tick();
    v1 = 1'b0;
    check("rd7_second", {rr_we, rr_wr, rr_wd, rr_gid}, {1'b1, 5'd7, 32'h5555, 1'b1});

    // Async reset while write_en is high
    v0 = 1'b1; rd0 = 5'd9; d0 = 32'h99;
    tick();
    v0 = 1'b0;
    check("mid_we_pre", rr_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_we_async_rr", rr_we, 1'b0);
    check("mid_we_async_fp", fp_we, 1'b0);
    check("mid_wr_async", rr_wr, 5'd0);
    tick();
    rst_n = 1'b1;
    v0 = 1'b1; rd0 = 5'd10; d0 = 32'hA0;
    v1 = 1'b1; rd1 = 5'd11; d1 = 32'hB0;
    #1;
    check("post_rst_tie_rr", {rr_rdy0, rr_rdy1}, 2'b10);
    check("post_rst_tie_fp", {fp_rdy0, fp_rdy1}, 2'b10);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    check("post_rst_out", {rr_we, rr_wr, rr_wd, rr_gid}, {1'b1, 5'd10, 32'hA0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
